// File: rtl/axil_regbank_pkg.sv
// Shared response codes and channel state encodings for the AXI4-Lite register bank.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axil_regbank_wjoin.sv
// AW/W one-entry buffers, address/data join and B response handshake.
// state  | meaning
// W_IDLE | accepting AW and W; commit fires once both are present
// W_RESP | BVALID high, waiting for BREADY
module axil_regbank_wjoin
  import axil_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic                    c_err,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   c_addr,
  output logic [DATA_WIDTH-1:0]   c_data,
  output logic [DATA_WIDTH/8-1:0] c_strb
);

  w_state_t                w_state, w_state_nxt;
  logic                    aw_full, w_full;
  logic [ADDR_WIDTH-1:0]   aw_buf;
  logic [DATA_WIDTH-1:0]   w_buf;
  logic [DATA_WIDTH/8-1:0] s_buf;
  logic                    aw_hs, w_hs;

  assign awready = !rst && (w_state == W_IDLE) && !aw_full;
  assign wready  = !rst && (w_state == W_IDLE) && !w_full;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign bvalid  = (w_state == W_RESP);

  // A beat arriving on the commit edge bypasses its buffer, so the
  // commit lands on the edge where the second half of the pair is accepted.
  assign commit = !rst && (w_state == W_IDLE) && (aw_full || aw_hs) && (w_full || w_hs);
  assign c_addr = aw_full ? aw_buf : awaddr;
  assign c_data = w_full ? w_buf : wdata;
  assign c_strb = w_full ? s_buf : wstrb;

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_nxt = W_RESP;
      W_RESP:  if (bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_buf  <= '0;
      w_buf   <= '0;
      s_buf   <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bresp   <= c_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_buf  <= awaddr;
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_buf  <= wdata;
          s_buf  <= wstrb;
        end
      end
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: address decode, byte-lane storage and read channel.
// state  | meaning
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high with captured data, waiting for RREADY
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                             DATA_WIDTH = 32,
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] word;
    word = a >> OFF_BITS;
    return (word >= ADDR_WIDTH'(NUM_REGS)) || (a[OFF_BITS-1:0] != '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF_BITS);
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] hw_arr;
  logic                                unused_prot;

  assign reg_q       = regs;
  assign hw_arr      = hw_in;
  assign unused_prot = ^{awprot, arprot};

  logic                  commit, w_err;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [IDX_W-1:0]      w_idx;

  assign w_idx = addr_idx(c_addr);
  assign w_err = addr_err(c_addr) || RO_MASK[w_idx];

  axil_regbank_wjoin #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wjoin (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .c_err   (w_err),
    .commit  (commit),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_strb  (c_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && !w_err) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (c_strb[b]) regs[w_idx][b*8 +: 8] <= c_data[b*8 +: 8];
        end
        wr_pulse[w_idx] <= 1'b1;
      end
    end
  end

  r_state_t         r_state, r_state_nxt;
  logic             ar_hs, r_err;
  logic [IDX_W-1:0] r_idx;

  assign arready = !rst && (r_state == R_IDLE);
  assign ar_hs   = arvalid && arready;
  assign rvalid  = (r_state == R_DATA);
  assign r_idx   = addr_idx(araddr);
  assign r_err   = addr_err(araddr);

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Reading regs (not the commit data) here returns the pre-write value
  // when a write to the same register commits on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        if (r_err) begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end else begin
          rdata <= RO_MASK[r_idx] ? hw_arr[r_idx] : regs[r_idx];
          rresp <= RESP_OKAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Scoreboard bench for axil_regbank: drivers queue expected B/R/pulse responses, a negedge monitor checks them.
module tb_axil_regbank;

  localparam int NR = 8;
  localparam logic [NR-1:0]    RO = 8'b0000_1000;
  localparam logic [NR*32-1:0] RV = 256'h55AA0001 << (5 * 32);
  localparam logic [1:0]       OK = 2'b00;
  localparam logic [1:0]       SE = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] hw_in, reg_q;
  logic [NR-1:0] wr_pulse;

  int n_total = 0;
  int n_pass  = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [7:0]  exp_p[$];

  axil_regbank #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (NR),
    .RO_MASK    (RO),
    .RESET_VAL  (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .awaddr   (awaddr),
    .awprot   (awprot),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arprot   (arprot),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .hw_in    (hw_in),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected: got bresp %h, expected no response", bresp);
      end else chk("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) begin
        n_total++;
        $display("FAIL r_unexpected: got rdata %h, expected no response", rdata);
      end else chk("rdata_rresp", {rdata, rresp}, exp_r.pop_front());
    end
    if (wr_pulse != '0) begin
      if (exp_p.size() == 0) begin
        n_total++;
        $display("FAIL pulse_unexpected: got wr_pulse %h, expected 00", wr_pulse);
      end else chk("wr_pulse", wr_pulse, exp_p.pop_front());
    end
  end

  task automatic send_aw(input logic [31:0] a);
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk); #1; awvalid = 1'b0; return;
      end
    end
    chk("aw_timeout", 1'b1, 1'b0);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk); #1; wvalid = 1'b0; return;
      end
    end
    chk("w_timeout", 1'b1, 1'b0);
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1; arvalid = 1'b0; return;
      end
    end
    chk("ar_timeout", 1'b1, 1'b0);
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp, input int pidx);
    exp_b.push_back(resp);
    if (pidx >= 0) exp_p.push_back(8'(1 << pidx));
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_r.push_back({d, resp});
    send_ar(a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
    hw_in = 256'hCAFEBABE << (3 * 32);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg_q", reg_q, RV);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    do_write(32'h00, 32'hDEADBEEF, 4'hF, OK, 0);
    do_read(32'h00, 32'hDEADBEEF, OK);
    do_write(32'h00, 32'h11223344, 4'h6, OK, 0);
    do_read(32'h00, 32'hDE2233EF, OK);

    exp_b.push_back(OK);
    exp_p.push_back(8'h02);
    send_w(32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_held_wready", wready, 1'b0);
      chk("w_held_bvalid", bvalid, 1'b0);
    end
    @(posedge clk); #1;
    send_aw(32'h04);
    @(negedge clk);
    chk("b_latency", bvalid, 1'b1);
    @(posedge clk); #1;
    do_read(32'h04, 32'hA5A5A5A5, OK);

    do_write(32'h08, 32'h12345678, 4'h1, OK, 2);
    do_read(32'h08, 32'h00000078, OK);

    do_read(32'hFFFFFFFC, 32'h0, SE);
    do_read(32'h02, 32'h0, SE);
    do_read(32'h20, 32'h0, SE);
    do_read(32'h1C, 32'h0, OK);
    do_write(32'hFFFFFFFC, 32'h1, 4'hF, SE, -1);
    do_write(32'h06, 32'h1, 4'hF, SE, -1);

    do_write(32'h0C, 32'h1, 4'hF, SE, -1);
    do_read(32'h0C, 32'hCAFEBABE, OK);
    chk("ro_reg_q", reg_q[3*32 +: 32], 32'h0);

    do_write(32'h10, 32'h1, 4'hF, OK, 4);
    repeat (2) @(posedge clk); #1;
    exp_b.push_back(OK);
    exp_p.push_back(8'h10);
    exp_r.push_back({32'h1, OK});
    fork
      send_aw(32'h10);
      send_w(32'h2, 4'hF);
      send_ar(32'h10);
    join
    do_read(32'h10, 32'h2, OK);

    repeat (3) @(posedge clk); #1;
    bready = 1'b0;
    exp_p.push_back(8'h20);
    fork
      send_aw(32'h14);
      send_w(32'h11111111, 4'hF);
    join
    @(negedge clk);
    chk("b_wait_bvalid", bvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_awready", awready, 1'b0);
    @(posedge clk); #1; rst = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    send_w(32'h77777777, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    send_aw(32'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abandon_bvalid", bvalid, 1'b0);
    end
    @(posedge clk); #1;
    exp_b.push_back(OK);
    exp_p.push_back(8'h01);
    send_w(32'h0BADF00D, 4'hF);
    do_read(32'h00, 32'h0BADF00D, OK);
    do_read(32'h14, 32'h55AA0001, OK);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    chk("p_queue_empty", exp_p.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
